// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown controller: state encoding and BCD digit limits.
package countdown_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled, tick flags the wrapping cycle.
module countdown_tick_gen #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// mm:ss countdown controller: edits/starts/pauses a BCD time from key pulses,
// counts down on prescaler ticks and holds an alarm for ALARM_SEC seconds.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned ALARM_SEC = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic               key_clr,
  input  logic               key_min,
  input  logic               key_sec,
  output logic [3:0]         min_tens,
  output logic [3:0]         min_ones,
  output logic [3:0]         sec_tens,
  output logic [3:0]         sec_ones,
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic               alarm
);

  localparam int unsigned    AC_W    = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [AC_W-1:0] AC_LAST = AC_W'(ALARM_SEC - 1);

  state_t          r_state;
  logic [3:0]      r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [15:0]     r_preset;
  logic [AC_W-1:0] r_alarm_cnt;
  logic            r_running, r_alarm;

  logic       w_tick, w_tick_en, w_tick_clr;
  logic       w_time_zero, w_dn_zero, w_any_edit;
  logic [3:0] w_inc_mt, w_inc_mo, w_inc_st, w_inc_so;
  logic [3:0] w_dn_mt, w_dn_mo, w_dn_st, w_dn_so;

  assign min_tens = r_min_tens;
  assign min_ones = r_min_ones;
  assign sec_tens = r_sec_tens;
  assign sec_ones = r_sec_ones;
  assign state    = r_state;
  assign running  = r_running;
  assign alarm    = r_alarm;

  always_comb begin
    w_time_zero = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0000);
    w_any_edit  = key_start || key_min || key_sec;

    w_inc_mt = r_min_tens;
    w_inc_mo = r_min_ones + 4'd1;
    if (r_min_ones == DIGIT_MAX) begin
      w_inc_mo = '0;
      w_inc_mt = (r_min_tens == DIGIT_MAX) ? '0 : r_min_tens + 4'd1;
    end

    w_inc_st = r_sec_tens;
    w_inc_so = r_sec_ones + 4'd1;
    if (r_sec_ones == DIGIT_MAX) begin
      w_inc_so = '0;
      w_inc_st = (r_sec_tens == SEC_TENS_MAX) ? '0 : r_sec_tens + 4'd1;
    end

    // Borrow chain: seconds first, then minutes with seconds reloaded to 59.
    w_dn_mt = r_min_tens;
    w_dn_mo = r_min_ones;
    w_dn_st = r_sec_tens;
    w_dn_so = r_sec_ones;
    if ({r_sec_tens, r_sec_ones} != 8'h00) begin
      if (r_sec_ones == 4'd0) begin
        w_dn_so = DIGIT_MAX;
        w_dn_st = r_sec_tens - 4'd1;
      end else begin
        w_dn_so = r_sec_ones - 4'd1;
      end
    end else if ({r_min_tens, r_min_ones} != 8'h00) begin
      w_dn_so = DIGIT_MAX;
      w_dn_st = SEC_TENS_MAX;
      if (r_min_ones == 4'd0) begin
        w_dn_mo = DIGIT_MAX;
        w_dn_mt = r_min_tens - 4'd1;
      end else begin
        w_dn_mo = r_min_ones - 4'd1;
      end
    end
    w_dn_zero = ({w_dn_mt, w_dn_mo, w_dn_st, w_dn_so} == 16'h0000);

    w_tick_en  = (r_state == ST_RUN) || (r_state == ST_DONE);
    w_tick_clr = key_clr
              || ((r_state == ST_IDLE) && key_start && !w_time_zero)
              || ((r_state == ST_RUN) && w_tick && w_dn_zero);
  end

  countdown_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_tick_en),
    .clr  (w_tick_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst || key_clr) begin
      r_state     <= ST_IDLE;
      r_min_tens  <= '0;
      r_min_ones  <= '0;
      r_sec_tens  <= '0;
      r_sec_ones  <= '0;
      r_preset    <= '0;
      r_alarm_cnt <= '0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (key_start) begin
            if (!w_time_zero) begin
              r_preset  <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end else if (key_min) begin
            r_min_tens <= w_inc_mt;
            r_min_ones <= w_inc_mo;
          end else if (key_sec) begin
            r_sec_tens <= w_inc_st;
            r_sec_ones <= w_inc_so;
          end
        end
        ST_RUN: begin
          // A tick coinciding with a pause pulse still lands; reaching zero wins over pausing.
          if (w_tick) begin
            {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} <= {w_dn_mt, w_dn_mo, w_dn_st, w_dn_so};
          end
          if (w_tick && w_dn_zero) begin
            r_state     <= ST_DONE;
            r_running   <= 1'b0;
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
          end else if (key_start) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (key_start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_any_edit || (w_tick && (r_alarm_cnt == AC_LAST))) begin
            {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} <= r_preset;
            r_state     <= ST_IDLE;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
          end else if (w_tick) begin
            r_alarm_cnt <= r_alarm_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random pulses
// compared against a seconds-based reference model.
module tb_countdown_ctrl;

  localparam int TD = 4;
  localparam int AS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start = 1'b0, key_clr = 1'b0, key_min = 1'b0, key_sec = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       running, alarm;

  int checks = 0;
  int errors = 0;

  // reference model: minutes/seconds as integers, state 0..3
  int m_min = 0, m_sec = 0, m_pre = 0, m_st = 0, m_pc = 0, m_ac = 0;

  countdown_ctrl #(.TICK_DIV(TD), .ALARM_SEC(AS)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_clr(key_clr),
    .key_min(key_min), .key_sec(key_sec),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic model_update(input bit r, input bit c, input bit s, input bit m, input bit k);
    bit tick;
    int t;
    tick = (m_st == 1 || m_st == 3) && (m_pc == TD - 1);
    if (m_st == 1 || m_st == 3) m_pc = (m_pc == TD - 1) ? 0 : m_pc + 1;
    if (r || c) begin
      m_min = 0; m_sec = 0; m_pre = 0; m_st = 0; m_pc = 0; m_ac = 0;
    end else begin
      case (m_st)
        0: begin
          if (s) begin
            if (m_min * 60 + m_sec != 0) begin
              m_pre = m_min * 60 + m_sec; m_st = 1; m_pc = 0;
            end
          end else if (m) m_min = (m_min + 1) % 100;
          else if (k) m_sec = (m_sec + 1) % 60;
        end
        1: begin
          if (tick) begin
            t = m_min * 60 + m_sec - 1;
            m_min = t / 60; m_sec = t % 60;
          end
          if (tick && m_min == 0 && m_sec == 0) begin
            m_st = 3; m_pc = 0; m_ac = 0;
          end else if (s) m_st = 2;
        end
        2: if (s) m_st = 1;
        default: begin
          if (s || m || k || (tick && m_ac == AS - 1)) begin
            m_st = 0; m_min = m_pre / 60; m_sec = m_pre % 60; m_ac = 0;
          end else if (tick) m_ac++;
        end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit m, input bit k);
    rst = r; key_clr = c; key_start = s; key_min = m; key_sec = k;
    @(posedge clk);
    model_update(r, c, s, m, k);
    #1;
    rst = 0; key_clr = 0; key_start = 0; key_min = 0; key_sec = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000)
      begin errors++; $display("FAIL reset_digits: got %h want 0000", {min_tens, min_ones, sec_tens, sec_ones}); end
    checks++;
    if ({state, running, alarm} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: state=%0d run=%b alarm=%b want 0/0/0", state, running, alarm); end
  endtask

  task automatic test_edit;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0302 || state !== 2'd0)
      begin errors++; $display("FAIL edit: got %h state=%0d want 0302 state=0", {min_tens, min_ones, sec_tens, sec_ones}, state); end
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (state !== 2'd0 || running !== 1'b0 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000)
      begin errors++; $display("FAIL start_zero: state=%0d run=%b want IDLE", state, running); end
  endtask

  task automatic test_countdown;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    checks++;
    if (state !== 2'd1 || running !== 1'b1)
      begin errors++; $display("FAIL start_run: state=%0d run=%b want 1/1", state, running); end
    idle(4);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001)
      begin errors++; $display("FAIL first_tick: got %h want 0001", {min_tens, min_ones, sec_tens, sec_ones}); end
    idle(3);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001 || state !== 2'd1)
      begin errors++; $display("FAIL before_done: got %h state=%0d want 0001/1", {min_tens, min_ones, sec_tens, sec_ones}, state); end
    idle(1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || state !== 2'd3 || alarm !== 1'b1 || running !== 1'b0)
      begin errors++; $display("FAIL done: got %h state=%0d alarm=%b want 0000/3/1", {min_tens, min_ones, sec_tens, sec_ones}, state, alarm); end
    idle(7);
    checks++;
    if (alarm !== 1'b1)
      begin errors++; $display("FAIL alarm_hold: alarm=%b want 1", alarm); end
    idle(1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0002 || state !== 2'd0 || alarm !== 1'b0)
      begin errors++; $display("FAIL alarm_end: got %h state=%0d alarm=%b want 0002/0/0", {min_tens, min_ones, sec_tens, sec_ones}, state, alarm); end
  endtask

  task automatic test_borrow_wrap;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    idle(4);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0059)
      begin errors++; $display("FAIL borrow: got %h want 0059", {min_tens, min_ones, sec_tens, sec_ones}); end
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0159)
      begin errors++; $display("FAIL sec_59: got %h want 0159", {min_tens, min_ones, sec_tens, sec_ones}); end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0100)
      begin errors++; $display("FAIL sec_wrap: got %h want 0100", {min_tens, min_ones, sec_tens, sec_ones}); end
    for (int i = 0; i < 98; i++) step(0, 0, 0, 1, 0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h9900)
      begin errors++; $display("FAIL min_99: got %h want 9900", {min_tens, min_ones, sec_tens, sec_ones}); end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000)
      begin errors++; $display("FAIL min_wrap: got %h want 0000", {min_tens, min_ones, sec_tens, sec_ones}); end
  endtask

  task automatic test_pause;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0);
    checks++;
    if (state !== 2'd2 || running !== 1'b0)
      begin errors++; $display("FAIL pause: state=%0d run=%b want 2/0", state, running); end
    idle(20);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0005 || state !== 2'd2)
      begin errors++; $display("FAIL pause_hold: got %h state=%0d want 0005/2", {min_tens, min_ones, sec_tens, sec_ones}, state); end
    step(0, 0, 1, 0, 0);
    idle(1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0005 || state !== 2'd1)
      begin errors++; $display("FAIL resume_early: got %h state=%0d want 0005/1", {min_tens, min_ones, sec_tens, sec_ones}, state); end
    idle(1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0004)
      begin errors++; $display("FAIL resume_tick: got %h want 0004", {min_tens, min_ones, sec_tens, sec_ones}); end
  endtask

  task automatic test_priority;
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || state !== 2'd0)
      begin errors++; $display("FAIL clr_over_start: got %h state=%0d want 0000/0", {min_tens, min_ones, sec_tens, sec_ones}, state); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0003 || state !== 2'd1)
      begin errors++; $display("FAIL min_in_run: got %h state=%0d want 0003/1", {min_tens, min_ones, sec_tens, sec_ones}, state); end
  endtask

  task automatic test_done_key_and_rst;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    idle(4);
    checks++;
    if (state !== 2'd3)
      begin errors++; $display("FAIL reach_done: state=%0d want 3", state); end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001 || state !== 2'd0 || alarm !== 1'b0)
      begin errors++; $display("FAIL done_key: got %h state=%0d alarm=%b want 0001/0/0", {min_tens, min_ones, sec_tens, sec_ones}, state, alarm); end
    step(0, 0, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, state, running, alarm} !== 20'h0)
      begin errors++; $display("FAIL rst_mid_run: got %h st=%0d run=%b al=%b want all 0", {min_tens, min_ones, sec_tens, sec_ones}, state, running, alarm); end
  endtask

  task automatic test_random;
    bit r, c, s, m, k;
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom % 400) == 0;
      c = ($urandom % 80) == 0;
      s = ($urandom % 12) == 0;
      m = ($urandom % 7) == 0;
      k = ($urandom % 5) == 0;
      step(r, c, s, m, k);
      checks++;
      if (min_tens !== 4'(m_min / 10) || min_ones !== 4'(m_min % 10) ||
          sec_tens !== 4'(m_sec / 10) || sec_ones !== 4'(m_sec % 10))
        begin errors++; $display("FAIL rand_digits@%0d: got %h want %0d:%0d", n, {min_tens, min_ones, sec_tens, sec_ones}, m_min, m_sec); end
      checks++;
      if (state !== 2'(m_st) || running !== (m_st == 1) || alarm !== (m_st == 3))
        begin errors++; $display("FAIL rand_state@%0d: got st=%0d run=%b al=%b want st=%0d", n, state, running, alarm, m_st); end
      checks++;
      if (sec_tens > 4'd5 || sec_ones > 4'd9 || min_tens > 4'd9 || min_ones > 4'd9)
        begin errors++; $display("FAIL rand_bcd_range@%0d: got %h want valid BCD", n, {min_tens, min_ones, sec_tens, sec_ones}); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_edit;
    test_countdown;
    test_borrow_wrap;
    test_pause;
    test_priority;
    test_done_key_and_rst;
    step(0, 1, 0, 0, 0);
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
